mod_check_sched: RTL and testbench
==================================

Name: mod_check_sched

Overview:
- Two-requester scheduler for the serial mod-N divisibility datapath.
- Arbitrates between two parallel-word requesters using round-robin.
- Captures the granted word and sequences it MSB-first, one bit per cycle, through an internal remainder engine: rem' = (2*rem + bit) mod DIVISOR.
- Returns the remainder, a divisible flag and the requester id on a valid/ready result channel. Fronts the serial divisibility checker for bus-attached producers.

Parameters:
- WIDTH, 8, data word width in bits, 2..32.
- DIVISOR, 5, modulus, 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  id of the requester that owns the result.
- res_div  out  1  1 when the word is divisible by DIVISOR.
- res_rem  out  4  word mod DIVISOR.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- States: IDLE, SHIFT, DONE. Registered state; ready signals are combinational from state and valids.
- Reset (rst==0 at a clk edge) forces:
  - state=IDLE, shift register=0, rem=0, count=0.
  - last_grant=1, so requester 0 wins the first tie.
  - res_valid=0, res_id=0, res_div=0, res_rem=0.
  - Reset overrides everything, including mid-SHIFT and mid-DONE; the in-flight word is discarded and no result is emitted.
- IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester != last_grant.
  - Grant asserts the granted reqX_ready in the same cycle. At the edge: load data into the shift register, rem=0, count=WIDTH, last_grant=granted id, latch the id, go to SHIFT.
  - No valid: stay in IDLE.
- Outside IDLE: req0_ready=req1_ready=0. No acceptance while busy; a requester keeps valid and data stable until it sees ready.
- SHIFT, each cycle:
  - t = 2*rem + msb, computed 5 bits wide.
  - rem = (t >= DIVISOR) ? t - DIVISOR : t. A single subtract suffices because t <= 2*DIVISOR-1.
  - Shift left by 1, count--.
  - When count reaches 0 after the WIDTH-th bit, go to DONE.
- DONE:
  - res_valid=1.
  - res_rem=final rem, res_div=(final rem==0), res_id=latched id.
  - Outputs are held stable until res_ready=1 at a clk edge, then go to IDLE with res_valid=0 next cycle.
  - res_ready while res_valid=0 is ignored.
- Latency: accept edge at cycle T, SHIFT occupies T+1..T+WIDTH, res_valid high from T+WIDTH+1. With res_ready tied high, next acceptance at T+WIDTH+2.
- Throughput: one word per WIDTH+2 cycles per requester pair. Arbitration is work-conserving, so a lone requester is never starved by last_grant.
- Word value 0 yields rem=0, div=1.
- res_rem upper bits are 0 when DIVISOR < 8.

Test Plan:
- Single word: after reset, req0 sends 8'd25, res_ready=1. Required: req0_ready high in the accept cycle; res_valid exactly 9 cycles later; res_id=0, res_div=1, res_rem=0.
- Remainder values: req1 sends 8'd26, then 8'd255, then 8'd0. Required:
  - 26: rem=1, div=0, id=1.
  - 255: rem=0, div=1.
  - 0: rem=0, div=1.
- Contention and fairness: both requesters hold valid continuously with 8'd7 (req0) and 8'd10 (req1). Required:
  - Grants alternate 0,1,0,1 starting with 0.
  - Results: id0 rem=2 div=0; id1 rem=0 div=1.
  - Neither ready is asserted while busy.
- Backpressure: hold res_ready=0 for 3 cycles in DONE. Required: res_valid, res_id, res_rem and res_div stay stable; both readies stay 0; IDLE is entered only after the res_ready edge.
- Mid-operation reset: pull rst low for 1 cycle during SHIFT of 8'd25. Required: next cycle busy=0, res_valid=0, last_grant=1, and no result is ever emitted for that word. A following 8'd13 on req1 yields rem=3.
- Parameter sweep: DIVISOR=3, WIDTH=12, word 12'd1000. Required: res_valid 13 cycles after accept, rem=1, div=0.

Source files
------------

// File: rtl/mod_check_sched.sv
// Two-requester round-robin front end for a serial mod-DIVISOR remainder engine.
// A granted word is shifted MSB-first through the engine and the result is offered on res_*.
module mod_check_sched #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_div,
    output logic [3:0]       res_rem,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [4:0]  Div  = 5'(DIVISOR);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [3:0]       rem_q, rem_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic             res_id_q, res_id_d;
    logic             res_div_q, res_div_d;
    logic [3:0]       res_rem_q, res_rem_d;

    logic             grant0, grant1;
    logic [4:0]       t;
    logic [3:0]       rem_step;

    // Work-conserving round-robin: last_grant only breaks ties.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = (state_q == StIdle) && grant0;
    assign req1_ready = (state_q == StIdle) && grant1;

    // t <= 2*DIVISOR-1, so one conditional subtract keeps rem in range.
    always_comb begin
        t        = {rem_q, 1'b0} + {4'b0000, shift_q[WIDTH-1]};
        rem_step = (t >= Div) ? 4'(t - Div) : t[3:0];
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rem_d        = rem_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        res_id_d     = res_id_q;
        res_div_d    = res_div_q;
        res_rem_d    = res_rem_q;

        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    shift_d      = grant1 ? req1_data : req0_data;
                    rem_d        = 4'd0;
                    count_d      = CntW'(WIDTH);
                    last_grant_d = grant1;
                    id_d         = grant1;
                    state_d      = StShift;
                end
            end
            StShift: begin
                rem_d   = rem_step;
                shift_d = shift_q << 1;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    res_rem_d = rem_step;
                    res_div_d = (rem_step == 4'd0);
                    res_id_d  = id_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            rem_q        <= 4'd0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            res_id_q     <= 1'b0;
            res_div_q    <= 1'b0;
            res_rem_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rem_q        <= rem_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            res_id_q     <= res_id_d;
            res_div_q    <= res_div_d;
            res_rem_q    <= res_rem_d;
        end
    end

    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign res_id    = res_id_q;
    assign res_div   = res_div_q;
    assign res_rem   = res_rem_q;

endmodule

// File: tb/tb_mod_check_sched.sv
// Randomized scoreboard bench for mod_check_sched, plus a directed WIDTH=12/DIVISOR=3 instance.
module tb_mod_check_sched;

    localparam int W = 8;
    localparam int D = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_data, req1_data;
    logic         res_valid, res_ready, res_id, res_div, busy;
    logic [3:0]   res_rem;

    mod_check_sched #(.WIDTH(W), .DIVISOR(D)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_div    (res_div),
        .res_rem    (res_rem),
        .busy       (busy)
    );

    // Second instance for the WIDTH=12, DIVISOR=3 corner.
    logic        rst2, v2, rdy2, res_valid2, res_id2, res_div2, busy2, r1_ready2;
    logic [11:0] d2;
    logic [3:0]  res_rem2;

    mod_check_sched #(.WIDTH(12), .DIVISOR(3)) u_dut2 (
        .clk        (clk),
        .rst        (rst2),
        .req0_valid (v2),
        .req0_data  (d2),
        .req0_ready (rdy2),
        .req1_valid (1'b0),
        .req1_data  (12'd0),
        .req1_ready (r1_ready2),
        .res_valid  (res_valid2),
        .res_ready  (1'b1),
        .res_id     (res_id2),
        .res_div    (res_div2),
        .res_rem    (res_rem2),
        .busy       (busy2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct packed {
        logic       id;
        logic [3:0] rem;
    } exp_t;

    exp_t       exp_q[$];
    logic [W-1:0] q0w[$];
    logic [W-1:0] q1w[$];

    // Reference model: 0 idle, 1 working through the bits, 2 result pending.
    int   m_mode = 0;
    int   m_left = 0;
    logic m_last = 1'b1;
    logic mon_en = 1'b0;
    logic acc0 = 1'b0, acc1 = 1'b0;
    logic done2 = 1'b0;

    logic       held_armed = 1'b0;
    logic       held_id, held_div;
    logic [3:0] held_rem;

    initial begin : monitor
        logic eg0, eg1;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                acc0 = 1'b0;
                acc1 = 1'b0;
                eg0 = (m_mode == 0) && req0_valid && (!req1_valid || m_last);
                eg1 = (m_mode == 0) && req1_valid && (!req0_valid || !m_last);
                check("req0_ready", int'(req0_ready), int'(eg0));
                check("req1_ready", int'(req1_ready), int'(eg1));
                check("busy", int'(busy), int'(m_mode != 0));
                check("res_valid", int'(res_valid), int'(m_mode == 2));
                if (res_valid && held_armed) begin
                    check("hold_id", int'(res_id), int'(held_id));
                    check("hold_rem", int'(res_rem), int'(held_rem));
                    check("hold_div", int'(res_div), int'(held_div));
                end
                if (res_valid && res_ready && rst) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_id", int'(res_id), int'(e.id));
                        check("res_rem", int'(res_rem), int'(e.rem));
                        check("res_div", int'(res_div), int'(e.rem == 4'd0));
                    end
                end
                held_armed = res_valid && !res_ready && rst;
                held_id    = res_id;
                held_rem   = res_rem;
                held_div   = res_div;

                if (!rst) begin
                    m_mode = 0;
                    m_last = 1'b1;
                    exp_q.delete();
                    held_armed = 1'b0;
                end else begin
                    case (m_mode)
                        0: if (eg0 || eg1) begin
                            e.id  = eg1;
                            e.rem = 4'((eg1 ? int'(req1_data) : int'(req0_data)) % D);
                            exp_q.push_back(e);
                            m_last = eg1;
                            m_mode = 1;
                            m_left = W;
                            acc0   = eg0;
                            acc1   = eg1;
                        end
                        1: begin
                            m_left--;
                            if (m_left == 0) m_mode = 2;
                        end
                        default: if (res_ready) m_mode = 0;
                    endcase
                end
            end
        end
    end

    int rr_mode = 0;
    int bp_cnt  = 0;

    task automatic cycle();
        @(negedge clk);
        if (acc0 && q0w.size() > 0) void'(q0w.pop_front());
        if (acc1 && q1w.size() > 0) void'(q1w.pop_front());
        req0_valid = (q0w.size() > 0);
        req0_data  = req0_valid ? q0w[0] : W'($urandom);
        req1_valid = (q1w.size() > 0);
        req1_data  = req1_valid ? q1w[0] : W'($urandom);
        case (rr_mode)
            0: res_ready = 1'b1;
            1: begin
                if (res_valid) bp_cnt++;
                else bp_cnt = 0;
                res_ready = (bp_cnt > 3);
            end
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin : stim
        int waited;
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        res_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        q0w.push_back(8'd25);
        run(15);

        q1w.push_back(8'd26);
        q1w.push_back(8'd255);
        q1w.push_back(8'd0);
        run(40);

        repeat (3) begin
            q0w.push_back(8'd7);
            q1w.push_back(8'd10);
        end
        run(70);

        rr_mode = 1;
        q0w.push_back(8'd50);
        q1w.push_back(8'd99);
        run(40);
        rr_mode = 0;

        // Abort a word mid-shift; no result may ever appear for it.
        q0w.push_back(8'd25);
        run(4);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        q1w.push_back(8'd13);
        run(20);

        // Fresh reset, then a tie: requester 0 must win.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        q0w.push_back(W'($urandom));
        q1w.push_back(W'($urandom));
        rr_mode = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0 && q0w.size() < 2) q0w.push_back(W'($urandom));
            if ($urandom_range(0, 5) == 0 && q1w.size() < 2) q1w.push_back(W'($urandom));
            cycle();
        end

        rr_mode = 0;
        waited  = 0;
        while ((q0w.size() > 0 || q1w.size() > 0 || m_mode != 0) && waited < 300) begin
            cycle();
            waited++;
        end
        check("drain_timeout", int'(waited < 300), 1);
        run(2);
        check("leftover_expected", exp_q.size(), 0);

        waited = 0;
        while (!done2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("dut2_timeout", int'(done2), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : dut2_seq
        int lat;
        rst2 = 1'b0;
        v2   = 1'b0;
        d2   = '0;
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        v2 = 1'b1;
        d2 = 12'd1000;
        #4;
        check("dut2_ready", int'(rdy2), 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            v2 = 1'b0;
            #4;
            if (res_valid2) begin
                lat = i;
                break;
            end
        end
        check("dut2_latency", lat, 13);
        check("dut2_rem", int'(res_rem2), 1000 % 3);
        check("dut2_div", int'(res_div2), int'((1000 % 3) == 0));
        check("dut2_id", int'(res_id2), 0);
        done2 = 1'b1;
    end

endmodule
